// File: rtl/bambu_mem_lane_arbiter_if.sv
// Bus bundle between the 2-lane Bambu master side (plus the shared RAM) and the lane arbiter.
// "master" is the HLS/RAM environment; "slave" is the arbiter.
interface bambu_mem_lane_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [1:0]          Mout_oe_ram;
  logic [1:0]          Mout_we_ram;
  logic [2*ADDR_W-1:0] Mout_addr_ram;
  logic [2*DATA_W-1:0] Mout_Wdata_ram;
  logic [7:0]          Mout_data_ram_size;
  logic [2*DATA_W-1:0] M_Rdata_ram;
  logic [1:0]          M_DataRdy;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_wmask;
  logic [DATA_W-1:0]   mem_rdata;
  logic                err_conflict;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, mem_rdata,
    input  M_Rdata_ram, M_DataRdy, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask, err_conflict
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, mem_rdata,
    output M_Rdata_ram, M_DataRdy, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask, err_conflict
  );
endinterface

// File: rtl/bambu_mem_lane_arbiter.sv
// Round-robin arbiter putting two Bambu master lanes onto one single-port synchronous RAM,
// one access in flight, with per-lane DataRdy/Rdata after fixed read/write latencies.
module bambu_mem_lane_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input logic clock,
  input logic reset,
  bambu_mem_lane_arbiter_if.slave bus
);
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic              grant, grant_next;
  logic              last_grant, last_grant_next;
  logic              lat_we, lat_we_next;
  logic [ADDR_W-1:0] lat_addr, lat_addr_next;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_next;
  logic [3:0]        lat_size, lat_size_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] rdata_cap, rdata_cap_next;
  logic              err, err_next;
  logic [1:0]        req, conflict;
  logic              sel;
  logic [DATA_W-1:0] wmask_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= '0;
      cnt        <= '0;
      rdata_cap  <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      lat_we     <= lat_we_next;
      lat_addr   <= lat_addr_next;
      lat_wdata  <= lat_wdata_next;
      lat_size   <= lat_size_next;
      cnt        <= cnt_next;
      rdata_cap  <= rdata_cap_next;
      err        <= err_next;
    end
  end

  // A lane with oe and we both high is a protocol error: it never counts as a request.
  always_comb begin
    req      = bus.Mout_oe_ram ^ bus.Mout_we_ram;
    conflict = bus.Mout_oe_ram & bus.Mout_we_ram;
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    lat_we_next     = lat_we;
    lat_addr_next   = lat_addr;
    lat_wdata_next  = lat_wdata;
    lat_size_next   = lat_size;
    cnt_next        = cnt;
    rdata_cap_next  = rdata_cap;
    err_next        = err;
    sel             = 1'b0;
    case (state)
      IDLE: begin
        if (|conflict) err_next = 1'b1;
        if (|req) begin
          sel             = (req == 2'b11) ? ~last_grant : req[1];
          grant_next      = sel;
          last_grant_next = sel;
          lat_we_next     = bus.Mout_we_ram[sel];
          lat_addr_next   = sel ? bus.Mout_addr_ram[ADDR_W +: ADDR_W] : bus.Mout_addr_ram[0 +: ADDR_W];
          lat_wdata_next  = sel ? bus.Mout_Wdata_ram[DATA_W +: DATA_W] : bus.Mout_Wdata_ram[0 +: DATA_W];
          lat_size_next   = sel ? bus.Mout_data_ram_size[7:4] : bus.Mout_data_ram_size[3:0];
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = lat_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          rdata_cap_next = lat_we ? '0 : bus.mem_rdata;
          state_next     = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Size is a bit count: the low 'size' bits are written, saturating at the full word.
  always_comb begin
    wmask_full = '0;
    for (int b = 0; b < DATA_W; b++) wmask_full[b] = (b < int'(lat_size));
  end

  always_comb begin
    bus.mem_en       = (state == ISSUE);
    bus.mem_we       = (state == ISSUE) && lat_we;
    bus.mem_addr     = lat_addr;
    bus.mem_wdata    = lat_wdata;
    bus.mem_wmask    = (state == ISSUE) ? wmask_full : '0;
    bus.M_DataRdy    = '0;
    bus.M_Rdata_ram  = '0;
    bus.err_conflict = err;
    if (state == RESP) begin
      bus.M_DataRdy[grant] = 1'b1;
      if (grant) bus.M_Rdata_ram[DATA_W +: DATA_W] = rdata_cap;
      else       bus.M_Rdata_ram[0 +: DATA_W]      = rdata_cap;
    end
  end
endmodule

// File: tb/tb_bambu_mem_lane_arbiter.sv
// Bench for bambu_mem_lane_arbiter: directed vector table and corner sequences, then random
// traffic checked cycle by cycle against a transaction-timeline reference model.
module tb_bambu_mem_lane_arbiter;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 1;

  typedef struct {
    bit         lane;
    bit         we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [3:0] size;
    logic [7:0] exp_mask;
    int         exp_rdy;
    logic [15:0] exp_rdata;
  } vec_t;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bambu_mem_lane_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  bambu_mem_lane_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment RAM: writes land on the mem_en edge, read data appears READ_LAT cycles after mem_en.
  logic [7:0] ram [128];
  logic [7:0] pipe1, pipe2;
  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= (ram[bus.mem_addr] & ~bus.mem_wmask) | (bus.mem_wdata & bus.mem_wmask);
      else            pipe1 <= ram[bus.mem_addr];
    end
    pipe2 <= pipe1;
  end
  assign bus.mem_rdata = pipe2;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] size_mask(input logic [3:0] s);
    int m;
    if (s >= 4'd8) return 8'hFF;
    m = (1 << s) - 1;
    return 8'(m);
  endfunction

  // Reference model: each grant is an event at cycle t that schedules mem_en at t+1, DataRdy at
  // t+2+latency and the next arbitration at the cycle after DataRdy.
  logic [7:0] ref_ram [128];
  bit         m_valid = 0;
  int         mcyc = 0;
  int         m_issue = -1, m_rdy = -1, m_free = 0;
  bit         m_err, m_last, m_lane, m_we;
  logic [6:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [3:0] m_size;

  always @(negedge clock) begin : ref_model
    logic [1:0]  rq;
    logic [7:0]  mk;
    logic [15:0] exp_rd;
    bit          ln;
    if (m_valid) begin
      exp_rd = m_we ? 16'h0 : (m_lane ? {m_rdata, 8'h00} : {8'h00, m_rdata});
      check_output($sformatf("model_mem_en@%0d", mcyc), 32'(bus.mem_en), 32'(mcyc == m_issue));
      check_output($sformatf("model_mem_we@%0d", mcyc), 32'(bus.mem_we), 32'(mcyc == m_issue && m_we));
      check_output($sformatf("model_mem_addr@%0d", mcyc), 32'(bus.mem_addr), 32'(m_addr));
      check_output($sformatf("model_mem_wdata@%0d", mcyc), 32'(bus.mem_wdata), 32'(m_wdata));
      check_output($sformatf("model_mem_wmask@%0d", mcyc), 32'(bus.mem_wmask),
                   32'((mcyc == m_issue) ? size_mask(m_size) : 8'h00));
      check_output($sformatf("model_datardy@%0d", mcyc), 32'(bus.M_DataRdy),
                   32'((mcyc == m_rdy) ? (m_lane ? 2'b10 : 2'b01) : 2'b00));
      check_output($sformatf("model_rdata@%0d", mcyc), 32'(bus.M_Rdata_ram),
                   32'((mcyc == m_rdy) ? exp_rd : 16'h0));
      check_output($sformatf("model_err@%0d", mcyc), 32'(bus.err_conflict), 32'(m_err));
    end
    if (reset) begin
      m_valid = 1; m_issue = -1; m_rdy = -1; m_free = mcyc + 1;
      m_err = 0; m_last = 1; m_lane = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_size = '0; m_rdata = '0;
    end else if (m_valid && mcyc >= m_free) begin
      if ((bus.Mout_oe_ram & bus.Mout_we_ram) != 2'b00) m_err = 1;
      rq = bus.Mout_oe_ram ^ bus.Mout_we_ram;
      if (rq != 2'b00) begin
        ln      = (rq == 2'b11) ? !m_last : rq[1];
        m_last  = ln;
        m_lane  = ln;
        m_we    = bus.Mout_we_ram[ln];
        m_addr  = ln ? bus.Mout_addr_ram[13:7] : bus.Mout_addr_ram[6:0];
        m_wdata = ln ? bus.Mout_Wdata_ram[15:8] : bus.Mout_Wdata_ram[7:0];
        m_size  = ln ? bus.Mout_data_ram_size[7:4] : bus.Mout_data_ram_size[3:0];
        m_issue = mcyc + 1;
        m_rdy   = mcyc + 2 + (m_we ? WRITE_LAT : READ_LAT);
        m_free  = m_rdy + 1;
        if (m_we) begin
          mk = size_mask(m_size);
          ref_ram[m_addr] = (ref_ram[m_addr] & ~mk) | (m_wdata & mk);
          m_rdata = 8'h00;
        end else begin
          m_rdata = ref_ram[m_addr];
        end
      end
    end
    mcyc++;
  end

  task automatic apply_stimulus(input logic [1:0] oe, input logic [1:0] we, input logic [13:0] addr,
                                input logic [15:0] wdata, input logic [7:0] size);
    @(posedge clock); #1;
    bus.Mout_oe_ram        = oe;
    bus.Mout_we_ram        = we;
    bus.Mout_addr_ram      = addr;
    bus.Mout_Wdata_ram     = wdata;
    bus.Mout_data_ram_size = size;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_output("reset_mem_en", 32'(bus.mem_en), 32'h0);
    check_output("reset_mem_we", 32'(bus.mem_we), 32'h0);
    check_output("reset_mem_addr", 32'(bus.mem_addr), 32'h0);
    check_output("reset_mem_wmask", 32'(bus.mem_wmask), 32'h0);
    check_output("reset_datardy", 32'(bus.M_DataRdy), 32'h0);
    check_output("reset_rdata", 32'(bus.M_Rdata_ram), 32'h0);
    check_output("reset_err", 32'(bus.err_conflict), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0]  lb;
    logic [13:0] a;
    logic [15:0] d;
    logic [7:0]  s;
    bit          seen;
    string       tag;
    lb  = v.lane ? 2'b10 : 2'b01;
    a   = v.lane ? {v.addr, 7'h00} : {7'h00, v.addr};
    d   = v.lane ? {v.wdata, 8'h00} : {8'h00, v.wdata};
    s   = v.lane ? {v.size, 4'h0} : {4'h0, v.size};
    tag = $sformatf("vec%0d", idx);
    apply_stimulus(v.we ? 2'b00 : lb, v.we ? lb : 2'b00, a, d, s);
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clock);
      check_output({tag, "_mem_en"}, 32'(bus.mem_en), 32'(c == 1));
      if (c == 1) begin
        check_output({tag, "_mem_we"}, 32'(bus.mem_we), 32'(v.we));
        check_output({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
        check_output({tag, "_mem_wmask"}, 32'(bus.mem_wmask), 32'(v.exp_mask));
        if (v.we) check_output({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
      end
      if (bus.M_DataRdy != 2'b00) begin
        seen = 1;
        check_output({tag, "_rdy_cycle"}, c, v.exp_rdy);
        check_output({tag, "_datardy"}, 32'(bus.M_DataRdy), 32'(lb));
        check_output({tag, "_rdata"}, 32'(bus.M_Rdata_ram), 32'(v.exp_rdata));
      end else begin
        check_output({tag, "_rdata_idle"}, 32'(bus.M_Rdata_ram), 32'h0);
      end
    end
    check_output({tag, "_rdy_seen"}, 32'(seen), 32'h1);
    apply_stimulus(2'b00, 2'b00, 14'h0, 16'h0, 8'h0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    vec_t       vecs [10];
    logic [1:0] hold, oe, we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [7:0] size;
    int         r;

    reset = 1'b1;
    bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0; bus.Mout_addr_ram = '0;
    bus.Mout_Wdata_ram = '0; bus.Mout_data_ram_size = '0;
    pipe1 = '0; pipe2 = '0;
    for (int i = 0; i < 128; i++) begin
      ram[i]     = (i < 64) ? 8'h00 : 8'($urandom);
      ref_ram[i] = ram[i];
    end
    ram[5] = 8'hA5; ref_ram[5] = 8'hA5;

    vecs[0] = '{1'b0, 1'b0, 7'h05, 8'h00, 4'd0,  8'h00, 4, 16'h00A5};
    vecs[1] = '{1'b1, 1'b1, 7'h10, 8'h3C, 4'd8,  8'hFF, 3, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 7'h10, 8'h00, 4'd0,  8'h00, 4, 16'h3C00};
    vecs[3] = '{1'b0, 1'b1, 7'h20, 8'hFF, 4'd4,  8'h0F, 3, 16'h0000};
    vecs[4] = '{1'b0, 1'b1, 7'h21, 8'hFF, 4'd0,  8'h00, 3, 16'h0000};
    vecs[5] = '{1'b1, 1'b1, 7'h22, 8'hA5, 4'd15, 8'hFF, 3, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 7'h20, 8'h00, 4'd0,  8'h00, 4, 16'h000F};
    vecs[7] = '{1'b1, 1'b0, 7'h21, 8'h00, 4'd0,  8'h00, 4, 16'h0000};
    vecs[8] = '{1'b0, 1'b1, 7'h22, 8'h00, 4'd3,  8'h07, 3, 16'h0000};
    vecs[9] = '{1'b1, 1'b0, 7'h22, 8'h00, 4'd0,  8'h00, 4, 16'hA000};

    repeat (2) @(posedge clock);
    apply_reset();
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    $display("[TB] contention: both lanes reading continuously");
    apply_reset();
    apply_stimulus(2'b11, 2'b00, {7'h10, 7'h05}, 16'h0, 8'h00);
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      check_output($sformatf("rr_mem_en@%0d", c), 32'(bus.mem_en), 32'(c == 1 || c == 6 || c == 11));
      check_output($sformatf("rr_datardy@%0d", c), 32'(bus.M_DataRdy),
                   (c == 4 || c == 14) ? 32'h1 : (c == 9) ? 32'h2 : 32'h0);
      check_output($sformatf("rr_rdata@%0d", c), 32'(bus.M_Rdata_ram),
                   (c == 4 || c == 14) ? 32'h00A5 : (c == 9) ? 32'h3C00 : 32'h0);
    end
    apply_stimulus(2'b00, 2'b00, 14'h0, 16'h0, 8'h0);

    $display("[TB] reset while a read is waiting");
    apply_stimulus(2'b01, 2'b00, 14'h05, 16'h0, 8'h0);
    @(negedge clock);
    @(negedge clock);
    check_output("rst_wait_issue", 32'(bus.mem_en), 32'h1);
    @(posedge clock); #1;
    reset = 1'b1;
    bus.Mout_oe_ram = 2'b00;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 3; c < 9; c++) begin
      @(negedge clock);
      check_output($sformatf("rst_wait_datardy@%0d", c), 32'(bus.M_DataRdy), 32'h0);
      check_output($sformatf("rst_wait_rdata@%0d", c), 32'(bus.M_Rdata_ram), 32'h0);
      check_output($sformatf("rst_wait_mem_en@%0d", c), 32'(bus.mem_en), 32'h0);
      if (c == 3) check_output("rst_wait_mem_addr", 32'(bus.mem_addr), 32'h0);
    end
    run_vec(vecs[0], 100);

    $display("[TB] conflicting lane alongside a normal read");
    apply_reset();
    apply_stimulus(2'b11, 2'b10, {7'h33, 7'h05}, 16'h0, 8'h0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clock);
      check_output($sformatf("conf_err@%0d", c), 32'(bus.err_conflict), 32'(c >= 1));
      check_output($sformatf("conf_mem_en@%0d", c), 32'(bus.mem_en), 32'(c == 1));
      check_output($sformatf("conf_datardy@%0d", c), 32'(bus.M_DataRdy), (c == 4) ? 32'h1 : 32'h0);
      if (c == 1) check_output("conf_mem_addr", 32'(bus.mem_addr), 32'h05);
      if (c == 4) begin
        check_output("conf_rdata", 32'(bus.M_Rdata_ram), 32'h00A5);
        @(posedge clock); #1;
        bus.Mout_oe_ram = 2'b10;
      end
    end
    apply_stimulus(2'b00, 2'b00, 14'h0, 16'h0, 8'h0);
    @(negedge clock);
    check_output("conf_err_sticky", 32'(bus.err_conflict), 32'h1);

    $display("[TB] random traffic against reference model");
    apply_reset();
    hold = 2'b00; oe = 2'b00; we = 2'b00; addr = '0; wdata = '0; size = '0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          r     = $urandom_range(0, 9);
          oe[i] = (r >= 4 && r <= 6) || (r == 9);
          we[i] = (r >= 7);
          hold[i] = (r >= 4 && r <= 8);
          addr[i*7 +: 7]  = 7'($urandom_range(0, 31));
          wdata[i*8 +: 8] = 8'($urandom);
          size[i*4 +: 4]  = 4'($urandom_range(0, 15));
        end
      end
      bus.Mout_oe_ram = oe; bus.Mout_we_ram = we; bus.Mout_addr_ram = addr;
      bus.Mout_Wdata_ram = wdata; bus.Mout_data_ram_size = size;
      @(negedge clock);
      hold = hold & ~bus.M_DataRdy;
    end
    @(posedge clock); #1;
    reset = 1'b0;
    bus.Mout_oe_ram = '0; bus.Mout_we_ram = '0;
    repeat (8) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
